// File: rtl/axi4_stream_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiter.
package axi4_stream_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam int DEF_NUM_INPUTS = 4;
  localparam int DEF_MAX_BURST  = 8;
  localparam int IDX_W          = $clog2(DEF_NUM_INPUTS);
  localparam int CNT_W          = $clog2(DEF_MAX_BURST + 1);

  // Upper bound on requester count that rr_pick can scan.
  localparam int MAX_INPUTS = 64;

  // Scans ptr, ptr+1, ... modulo n; returns 1 and the winner in idx if any bit is set.
  function automatic logic rr_pick(input logic [MAX_INPUTS-1:0] valid,
                                   input int ptr,
                                   input int n,
                                   output int idx);
    logic found;
    int   j;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < MAX_INPUTS; k++) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (!found && valid[j]) begin
          found = 1'b1;
          idx   = j;
        end
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/axi4_stream_out_reg.sv
// Single-entry registered AXI4-Stream output stage carrying data and a source tag.
module axi4_stream_out_reg #(
  parameter int DATA_W = 16,
  parameter int TID_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TID_W-1:0]  in_tid,
  input  logic              in_valid,
  output logic              ready,
  output logic [DATA_W-1:0] out_tdata,
  output logic [TID_W-1:0]  out_tid,
  output logic              out_tvalid,
  input  logic              out_tready
);

  // The register can take a new beat when empty or when its beat leaves this cycle.
  assign ready = !out_tvalid || out_tready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tid    <= '0;
    end else if (ready) begin
      out_tvalid <= in_valid;
      if (in_valid) begin
        out_tdata <= in_data;
        out_tid   <= in_tid;
      end
    end
  end

endmodule

// File: rtl/axi4_stream_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Stream sink between NUM_INPUTS requesters,
// with a bounded burst per grant and a registered, source-tagged output.
module axi4_stream_rr_arbiter
  import axi4_stream_arb_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_INPUTS*DATA_SIZE-1:0] in_tdata,
  input  logic [NUM_INPUTS-1:0]           in_tvalid,
  output logic [NUM_INPUTS-1:0]           in_tready,
  output logic [DATA_SIZE-1:0]            out_tdata,
  output logic [$clog2(NUM_INPUTS)-1:0]   out_tid,
  output logic                            out_tvalid,
  input  logic                            out_tready,
  output logic                            busy_o,
  output logic [$clog2(NUM_INPUTS)-1:0]   grant_o
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        grant;
  logic [CW-1:0]        beat_cnt;
  logic                 adv;
  logic                 accept;
  logic                 release_grant;
  logic                 pick_found;
  int                   pick_idx;
  logic [DATA_SIZE-1:0] grant_data;

  always_comb begin
    pick_idx   = 0;
    pick_found = rr_pick(MAX_INPUTS'(in_tvalid), int'(rr_ptr), NUM_INPUTS, pick_idx);
  end

  assign grant_data = in_tdata[grant*DATA_SIZE +: DATA_SIZE];
  assign accept     = (state == GRANT) && in_tvalid[grant] && adv;

  // A grant ends on its last allowed beat or as soon as the owner stops offering data.
  assign release_grant = (state == GRANT) &&
                         (!in_tvalid[grant] || (accept && beat_cnt == CW'(MAX_BURST - 1)));

  always_comb begin
    in_tready = '0;
    if (state == GRANT) in_tready[grant] = adv;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant    <= IW'(pick_idx);
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) beat_cnt <= beat_cnt + 1'b1;
          if (release_grant) begin
            state  <= IDLE;
            rr_ptr <= (grant == IW'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy_o  = (state == GRANT);
  assign grant_o = grant;

  axi4_stream_out_reg #(
    .DATA_W (DATA_SIZE),
    .TID_W  (IW)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_data    (grant_data),
    .in_tid     (grant),
    .in_valid   (accept),
    .ready      (adv),
    .out_tdata  (out_tdata),
    .out_tid    (out_tid),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  assert property (@(posedge clk_i) $onehot0(in_tready));

  assert property (@(posedge clk_i) disable iff (rst_i)
    (out_tvalid && !out_tready) |=> (out_tvalid && $stable(out_tdata) && $stable(out_tid)));

endmodule

// File: tb/tb_axi4_stream_rr_arbiter.sv
// Randomized and directed bench for axi4_stream_rr_arbiter, checked every cycle
// against a behavioural arbitration model plus an in-order beat scoreboard.
module tb_axi4_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N*DW-1:0] in_tdata;
  logic [N-1:0]    in_tvalid;
  logic [N-1:0]    in_tready;
  logic [DW-1:0]   out_tdata;
  logic [1:0]      out_tid;
  logic            out_tvalid;
  logic            out_tready;
  logic            busy_o;
  logic [1:0]      grant_o;

  logic            rst3;
  logic [3*DW-1:0] tdata3;
  logic [2:0]      tvalid3;
  logic [2:0]      tready3;
  logic [DW-1:0]   out_tdata3;
  logic [1:0]      out_tid3;
  logic            out_tvalid3;
  logic            busy3;
  logic [1:0]      grant3;

  always #5 clk = ~clk;

  axi4_stream_rr_arbiter #(.DATA_SIZE(DW), .NUM_INPUTS(N), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(in_tready), .out_tdata(out_tdata), .out_tid(out_tid),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .busy_o(busy_o), .grant_o(grant_o)
  );

  axi4_stream_rr_arbiter #(.DATA_SIZE(DW), .NUM_INPUTS(3), .MAX_BURST(MB)) dut3 (
    .clk_i(clk), .rst_i(rst3), .in_tdata(tdata3), .in_tvalid(tvalid3),
    .in_tready(tready3), .out_tdata(out_tdata3), .out_tid(out_tid3),
    .out_tvalid(out_tvalid3), .out_tready(1'b1), .busy_o(busy3), .grant_o(grant3)
  );

  typedef struct {logic [DW-1:0] data; logic [1:0] tid;} sb_t;
  typedef struct {int cyc; logic [DW-1:0] data; logic [1:0] tid;} beat_t;

  int       n_vec = 0;
  int       n_err = 0;
  int       cyc = 0;
  sb_t      sb[$];
  beat_t    out_log[$];
  int       grant_log[$];
  int       rem[N];
  int       seq[N];
  int       wait_cnt[N];
  int       max_wait;
  logic [N-1:0] en;
  logic [N-1:0] acc_prev;
  logic     prev_busy = 1'b0;

  // Behavioural view of the arbiter: who owns the sink, burst progress, output register.
  logic          m_known = 1'b0;
  logic          m_busy;
  int            m_grant, m_ptr, m_cnt;
  logic          m_ov;
  logic [DW-1:0] m_od;
  int            m_ot;

  function automatic logic [DW-1:0] word(input int i, input int s);
    return DW'((i + 1) * 4096 + s);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic all_idle();
    logic idle;
    idle = !busy_o && !out_tvalid;
    for (int i = 0; i < N; i++) if (rem[i] != 0) idle = 1'b0;
    return idle;
  endfunction

  always @(negedge clk) begin : compare
    logic         adv, acc, rel, was_busy;
    logic [N-1:0] exp_ready;
    sb_t          s;
    #2;
    if (m_known) begin
      adv       = !m_ov || out_tready;
      exp_ready = '0;
      if (m_busy && adv) exp_ready[m_grant] = 1'b1;
      check_output("in_tready", 32'(in_tready), 32'(exp_ready));
      check_output("out_tvalid", 32'(out_tvalid), 32'(m_ov));
      check_output("busy_o", 32'(busy_o), 32'(m_busy));
      check_output("grant_o", 32'(grant_o), 32'(m_grant));
      if (m_ov) begin
        check_output("out_tdata", 32'(out_tdata), 32'(m_od));
        check_output("out_tid", 32'(out_tid), 32'(m_ot));
      end
      if (out_tvalid && !out_tready) check_output("stall_in_tready", 32'(in_tready), 32'd0);
      if (out_tvalid && out_tready) begin
        check_output("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          s = sb.pop_front();
          check_output("sb_data", 32'(out_tdata), 32'(s.data));
          check_output("sb_tid", 32'(out_tid), 32'(s.tid));
        end
        out_log.push_back('{cyc, out_tdata, out_tid});
      end
      for (int i = 0; i < N; i++)
        if (in_tvalid[i] && in_tready[i]) sb.push_back('{in_tdata[i*DW +: DW], 2'(i)});
      if (busy_o && !prev_busy) grant_log.push_back(int'(grant_o));
      for (int i = 0; i < N; i++) begin
        if (busy_o && grant_o == 2'(i)) wait_cnt[i] = 0;
        else if (in_tvalid[i] && busy_o) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    acc_prev = m_known ? (in_tvalid & in_tready) : '0;

    if (rst_i) begin
      m_known = 1'b1; m_busy = 1'b0; m_grant = 0; m_ptr = 0; m_cnt = 0;
      m_ov = 1'b0; m_od = '0; m_ot = 0;
    end else if (m_known) begin
      adv      = !m_ov || out_tready;
      was_busy = m_busy;
      acc      = m_busy && in_tvalid[m_grant] && adv;
      rel      = m_busy && (!in_tvalid[m_grant] || (acc && m_cnt == MB - 1));
      if (adv) begin
        m_ov = acc;
        if (acc) begin
          m_od = in_tdata[m_grant*DW +: DW];
          m_ot = m_grant;
        end
      end
      if (!was_busy) begin
        for (int k = 0; k < N; k++) begin
          if (in_tvalid[(m_ptr + k) % N]) begin
            m_busy = 1'b1; m_grant = (m_ptr + k) % N; m_cnt = 0;
            break;
          end
        end
      end else begin
        if (acc) m_cnt++;
        if (rel) begin
          m_busy = 1'b0;
          m_ptr  = (m_grant + 1) % N;
        end
      end
    end
    if (rst_i) sb.delete();
    prev_busy = busy_o;
    cyc++;
  end

  task automatic apply_stimulus(input logic rst, input logic rdy);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc_prev[i]) begin
        seq[i]++;
        if (rem[i] > 0) rem[i]--;
      end
    end
    acc_prev   = '0;
    rst_i      = rst;
    out_tready = rdy;
    for (int i = 0; i < N; i++) begin
      in_tvalid[i]           = (rem[i] > 0) && en[i];
      in_tdata[i*DW +: DW]   = word(i, seq[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      apply_stimulus(1'b0, 1'b1);
      #3;
      if (all_idle()) break;
      n++;
      if (n > 400) begin
        check_output("drain_done", 32'(all_idle()), 32'd1);
        break;
      end
    end
  endtask

  task automatic clear_logs();
    out_log.delete();
    grant_log.delete();
  endtask

  initial begin
    int t0, n, base[N];
    int exp_order[5];
    logic pb3;
    int   g3[$];
    exp_order = '{0, 1, 2, 3, 0};
    rst_i = 1'b1; out_tready = 1'b1; in_tvalid = '0; in_tdata = '0;
    rst3 = 1'b1; tvalid3 = '0; tdata3 = 48'h3003_2002_1001;
    en = '1; acc_prev = '0; max_wait = 0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; wait_cnt[i] = 0; end

    // Reset state
    repeat (2) apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    #3;
    check_output("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_grant", 32'(grant_o), 32'd0);
    check_output("rst_in_tready", 32'(in_tready), 32'd0);

    // Single requester, 10 beats against an 8-beat limit
    clear_logs();
    rem[0] = 10;
    apply_stimulus(1'b0, 1'b1);
    t0 = cyc;
    drain();
    check_output("single_count", 32'(out_log.size()), 32'd10);
    if (out_log.size() == 10) begin
      check_output("single_latency", 32'(out_log[0].cyc - t0), 32'd2);
      for (int i = 0; i < 10; i++) begin
        check_output("single_data", 32'(out_log[i].data), 32'(16'h1000 + i));
        check_output("single_tid", 32'(out_log[i].tid), 32'd0);
        if (i > 0) check_output("single_gap", 32'(out_log[i].cyc - out_log[i-1].cyc),
                                (i == 8) ? 32'd2 : 32'd1);
      end
    end

    // Full contention
    repeat (2) apply_stimulus(1'b1, 1'b1);
    clear_logs();
    max_wait = 0;
    for (int i = 0; i < N; i++) begin base[i] = seq[i]; rem[i] = 16; wait_cnt[i] = 0; end
    drain();
    check_output("contend_grants", 32'(grant_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) check_output("contend_order", 32'(grant_log[k]), 32'(exp_order[k]));
    check_output("contend_count", 32'(out_log.size()), 32'd64);
    for (int k = 0; k < out_log.size(); k++) begin
      check_output("contend_tid", 32'(out_log[k].tid), 32'((k / 8) % 4));
      check_output("contend_data", 32'(out_log[k].data),
                   32'(word((k / 8) % 4, base[(k / 8) % 4] + (k / 32) * 8 + k % 8)));
    end
    check_output("contend_wait_ok", 32'(max_wait <= 3 * (MB + 1)), 32'd1);

    // Backpressure on stream 2 with out_tready = 1,0,0,...
    clear_logs();
    base[2] = seq[2];
    rem[2] = 12;
    n = 0;
    forever begin
      apply_stimulus(1'b0, (n % 3) == 0);
      #3;
      n++;
      if (all_idle() || n > 300) break;
    end
    check_output("bp_finished", 32'(all_idle()), 32'd1);
    check_output("bp_count", 32'(out_log.size()), 32'd12);
    for (int i = 0; i < out_log.size(); i++) begin
      check_output("bp_data", 32'(out_log[i].data), 32'(word(2, base[2] + i)));
      check_output("bp_tid", 32'(out_log[i].tid), 32'd2);
    end

    // Early release: stream 1 stops after 3 beats while stream 3 waits
    repeat (2) apply_stimulus(1'b1, 1'b1);
    clear_logs();
    base[1] = seq[1];
    rem[1] = 3;
    rem[3] = 4;
    drain();
    check_output("early_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check_output("early_first", 32'(grant_log[0]), 32'd1);
      check_output("early_next", 32'(grant_log[1]), 32'd3);
    end
    check_output("early_count", 32'(out_log.size()), 32'd7);
    for (int i = 0; i < out_log.size(); i++)
      check_output("early_tid", 32'(out_log[i].tid), (i < 3) ? 32'd1 : 32'd3);
    if (out_log.size() >= 3)
      for (int i = 0; i < 3; i++)
        check_output("early_data", 32'(out_log[i].data), 32'(word(1, base[1] + i)));

    // Reset in the middle of a stalled stream-0 burst
    rem[0] = 20;
    repeat (5) apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    grant_log.delete();
    #3;
    check_output("pre_reset_valid", 32'(out_tvalid), 32'd1);
    rem[2] = 5;
    apply_stimulus(1'b0, 1'b1);
    #3;
    check_output("mid_rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check_output("mid_rst_in_tready", 32'(in_tready), 32'd0);
    check_output("mid_rst_busy", 32'(busy_o), 32'd0);
    check_output("mid_rst_grant", 32'(grant_o), 32'd0);
    drain();
    check_output("post_rst_grants", 32'(grant_log.size() >= 1), 32'd1);
    if (grant_log.size() >= 1) check_output("post_rst_first", 32'(grant_log[0]), 32'd0);

    // Randomized traffic, backpressure and occasional resets
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = int'($urandom_range(1, 20));
        en[i] = ($urandom_range(0, 3) != 0);
      end
      apply_stimulus($urandom_range(0, 399) == 0, $urandom_range(0, 2) != 0);
    end
    en = '1;
    drain();
    check_output("sb_empty", 32'(sb.size()), 32'd0);

    // Wrap-around with three requesters, pointer parked at 2
    pb3 = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      rst3    = (i < 2);
      tvalid3 = (i < 2) ? 3'b000 : (i == 2) ? 3'b010 : 3'b101;
      #3;
      if (busy3 && !pb3) g3.push_back(int'(grant3));
      pb3 = busy3;
    end
    check_output("wrap_grants", 32'(g3.size() >= 3), 32'd1);
    if (g3.size() >= 3) begin
      check_output("wrap_g0", 32'(g3[0]), 32'd1);
      check_output("wrap_g1", 32'(g3[1]), 32'd2);
      check_output("wrap_g2", 32'(g3[2]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
